// File: rtl/find_n_grant_scheduler.sv
// Multi-slot scheduler: up to N of W requesters own a shared slot until they pulse done.
// Define FRIC_SCHED_RR_EN for a rotating search pointer; otherwise priority is fixed MSB-first.
module find_n_grant_scheduler #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             req,
  input  logic [W-1:0]             done,
  output logic [W-1:0]             grant,
  output logic [W-1:0]             grant_pulse,
  output logic [$clog2(N+1)-1:0]   busy_cnt,
  output logic                     full
);

  localparam int PTR_W = $clog2(W);
  localparam int CNT_W = $clog2(N+1);
  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(W - 1);

  function automatic int popcount(input logic [W-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) c = c + 1;
    end
    return c;
  endfunction

  // Keeps the first n ones of v scanning from the MSB down.
  function automatic logic [W-1:0] find_first_n_ones(input logic [W-1:0] v, input int n);
    logic [W-1:0] sel;
    int           cnt;
    sel = '0;
    cnt = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i] && (cnt < n)) begin
        sel[i] = 1'b1;
        cnt    = cnt + 1;
      end
    end
    return sel;
  endfunction

  // Bit p of v lands on the MSB; lower rotated bits follow the downward wrap order.
  function automatic logic [W-1:0] rotate_to_msb(input logic [W-1:0] v, input int p);
    logic [W-1:0] r;
    for (int j = 0; j < W; j++) begin
      r[W-1-j] = v[(p + W - j) % W];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rotate_from_msb(input logic [W-1:0] r, input int p);
    logic [W-1:0] v;
    for (int j = 0; j < W; j++) begin
      v[(p + W - j) % W] = r[W-1-j];
    end
    return v;
  endfunction

  logic [W-1:0]     grant_q, grant_d;
  logic [W-1:0]     pulse_q, pulse_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             full_q, full_d;
  logic [PTR_W-1:0] ptr;

  logic [W-1:0] keep;
  logic [W-1:0] cand;
  logic [W-1:0] cand_rot;
  logic [W-1:0] sel_rot;
  logic [W-1:0] new_grant;
  int           k_free;
  int           ptr_i;

  assign ptr_i = int'(ptr);

  // Released owners are not re-eligible this cycle, but their slots are.
  always_comb begin
    keep      = grant_q & ~done;
    cand      = req & ~grant_q;
    k_free    = N - popcount(keep);
    cand_rot  = rotate_to_msb(cand, ptr_i);
    sel_rot   = find_first_n_ones(cand_rot, k_free);
    new_grant = rotate_from_msb(sel_rot, ptr_i);
  end

  always_comb begin
    grant_d    = keep | new_grant;
    pulse_d    = new_grant;
    busy_cnt_d = CNT_W'(popcount(grant_d));
    full_d     = (popcount(grant_d) == N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= '0;
      pulse_q    <= '0;
      busy_cnt_q <= '0;
      full_q     <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      pulse_q    <= pulse_d;
      busy_cnt_q <= busy_cnt_d;
      full_q     <= full_d;
    end
  end

`ifdef FRIC_SCHED_RR_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;
  int               last_j;

  // Next search starts just below the last requester granted in search order.
  always_comb begin
    last_j = 0;
    for (int j = 0; j < W; j++) begin
      if (sel_rot[W-1-j]) last_j = j;
    end
    ptr_d = ptr_q;
    if (|new_grant) ptr_d = PTR_W'((ptr_i - last_j - 1 + 2 * W) % W);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PTR_TOP;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = PTR_TOP;
`endif

  assign grant       = grant_q;
  assign grant_pulse = pulse_q;
  assign busy_cnt    = busy_cnt_q;
  assign full        = full_q;

endmodule
